countdown_timer: RTL and testbench

Count-down mm:ss timer for the clock design; it decrements minutes and seconds where the existing counters increment them. It consumes the same 1 Hz seconds tick the time-of-day counters use. It produces a seconds-borrow pulse, where the up-counters produce a carry, and an expiry flag for the alarm/buzzer logic. It is loaded from the set-time path and controlled by start/stop strobes from the button debouncers.

---
 rtl/clock_pkg.sv | 23 ++
 rtl/mod60_down_counter.sv | 36 +++
 rtl/countdown_timer.sv | 167 ++++++++++++++++
 tb/tb_countdown_timer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the clock design's time counters.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clock_pkg;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    typedef logic [5:0] time6_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

    // Clamp a preset to the highest legal value for its field.
    function automatic time6_t sat6(input time6_t v, input time6_t lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/mod60_down_counter.sv
// Loadable 6-bit down counter that wraps from 0 to a wrap value and flags the wrap.
// Latency: value updates one clk after load/decrement; is_zero and borrow are combinational.
// Backpressure: none; load and decrement are accepted every cycle, load has priority.
module mod60_down_counter
    import clock_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_load,
    input  time6_t i_load_val,
    input  logic   i_dec_en,
    input  time6_t i_wrap_val,
    output time6_t o_value,
    output logic   o_is_zero,
    output logic   o_borrow
);

    time6_t r_value;

    assign o_value   = r_value;
    assign o_is_zero = (r_value == '0);
    // Borrow only when a real decrement wraps; a load on the same edge suppresses it.
    assign o_borrow  = i_dec_en && !i_load && o_is_zero;

    // Counter register: load beats decrement, decrement wraps 0 -> wrap value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= i_load_val;
        end else if (i_dec_en) begin
            r_value <= o_is_zero ? i_wrap_val : (r_value - 6'd1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown timer with load/start/stop control, seconds borrow and expiry flags.
// Latency: every output changes one clk after the sampling edge; all outputs registered.
// Backpressure: none; strobes are sampled every edge with priority load > stop > start > tick.
// Build option COUNTDOWN_AUTO_RELOAD_EN: on reaching 00:00 reload the last preset and keep running.
module countdown_timer
    import clock_pkg::*;
#(
    parameter int MAX_MIN = MIN_MAX,
    parameter int MAX_SEC = SEC_MAX
) (
    input  logic       clk,
    input  logic       reset_all_n,
    input  logic       tick_1hz,
    input  logic       load,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       start,
    input  logic       stop,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       borrow_sec,
    output logic       running,
    output logic       done,
    output logic       done_pulse
);

    localparam time6_t LP_MAX_MIN = time6_t'(MAX_MIN);
    localparam time6_t LP_MAX_SEC = time6_t'(MAX_SEC);

    timer_state_t r_state;
    timer_state_t w_state_nxt;

    time6_t r_rel_min;
    time6_t r_rel_sec;
    logic   r_borrow_sec;
    logic   r_running;
    logic   r_done;
    logic   r_done_pulse;

    time6_t w_sat_min;
    time6_t w_sat_sec;
    time6_t w_min;
    time6_t w_sec;
    time6_t w_min_ld_val;
    time6_t w_sec_ld_val;
    logic   w_min_zero;
    logic   w_sec_zero;
    logic   w_sec_borrow;
    logic   w_min_borrow;
    logic   w_tick_dec;
    logic   w_expire;
    logic   w_reload;
    logic   w_cnt_load;

    assign w_sat_min = sat6(load_min, LP_MAX_MIN);
    assign w_sat_sec = sat6(load_sec, LP_MAX_SEC);

    // A tick only counts in RUN when neither load nor stop claims the edge.
    assign w_tick_dec = (r_state == RUN) && tick_1hz && !load && !stop;

    // 00:01 -> 00:00 on this edge. A minutes underflow cannot happen from RUN,
    // but if it ever did it is treated as expiry rather than a silent wrap.
    assign w_expire = (w_tick_dec && w_min_zero && (w_sec == 6'd1)) || w_min_borrow;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // An all-zero preset cannot be reloaded usefully, so it still expires.
    assign w_reload = w_expire && !((r_rel_min == '0) && (r_rel_sec == '0));
`else
    assign w_reload = 1'b0;
`endif

    assign w_cnt_load   = load || w_reload;
    assign w_min_ld_val = load ? w_sat_min : r_rel_min;
    assign w_sec_ld_val = load ? w_sat_sec : r_rel_sec;

    mod60_down_counter u_sec (
        .clk        (clk),
        .rst_n      (reset_all_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_sec_ld_val),
        .i_dec_en   (w_tick_dec),
        .i_wrap_val (LP_MAX_SEC),
        .o_value    (w_sec),
        .o_is_zero  (w_sec_zero),
        .o_borrow   (w_sec_borrow)
    );

    mod60_down_counter u_min (
        .clk        (clk),
        .rst_n      (reset_all_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_min_ld_val),
        .i_dec_en   (w_sec_borrow),
        .i_wrap_val (LP_MAX_MIN),
        .o_value    (w_min),
        .o_is_zero  (w_min_zero),
        .o_borrow   (w_min_borrow)
    );

    // Next-state logic; stop masks start in every state.
    always_comb begin
        w_state_nxt = r_state;
        if (load) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE, PAUSE: begin
                    if (start && !stop && !(w_min_zero && w_sec_zero)) begin
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        w_state_nxt = PAUSE;
                    end else if (w_expire && !w_reload) begin
                        w_state_nxt = EXPIRED;
                    end
                end
                EXPIRED: w_state_nxt = EXPIRED;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_all_n) begin
        if (!reset_all_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Reload register holds the last saturated preset.
    always_ff @(posedge clk or negedge reset_all_n) begin
        if (!reset_all_n) begin
            r_rel_min <= '0;
            r_rel_sec <= '0;
        end else if (load) begin
            r_rel_min <= w_sat_min;
            r_rel_sec <= w_sat_sec;
        end
    end

    // Registered status flags, aligned with the counter values.
    always_ff @(posedge clk or negedge reset_all_n) begin
        if (!reset_all_n) begin
            r_borrow_sec <= 1'b0;
            r_running    <= 1'b0;
            r_done       <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_borrow_sec <= w_sec_borrow;
            r_running    <= (w_state_nxt == RUN);
            r_done       <= (w_state_nxt == EXPIRED);
            r_done_pulse <= w_expire;
        end
    end

    assign min        = w_min;
    assign sec        = w_sec;
    assign borrow_sec = r_borrow_sec;
    assign running    = r_running;
    assign done       = r_done;
    assign done_pulse = r_done_pulse;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random stimulus
// compared against a total-seconds reference model.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_countdown_timer;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_EXP   = 3;

    logic       clk = 1'b0;
    logic       reset_all_n;
    logic       tick_1hz;
    logic       load;
    logic [5:0] load_min;
    logic [5:0] load_sec;
    logic       start;
    logic       stop;
    logic [5:0] min;
    logic [5:0] sec;
    logic       borrow_sec;
    logic       running;
    logic       done;
    logic       done_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_min, m_sec, m_rel_min, m_rel_sec, m_state;
    bit m_borrow, m_pulse;

    countdown_timer dut (
        .clk        (clk),
        .reset_all_n(reset_all_n),
        .tick_1hz   (tick_1hz),
        .load       (load),
        .load_min   (load_min),
        .load_sec   (load_sec),
        .start      (start),
        .stop       (stop),
        .min        (min),
        .sec        (sec),
        .borrow_sec (borrow_sec),
        .running    (running),
        .done       (done),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dut_vec();
        return {min, sec, borrow_sec, running, done, done_pulse};
    endfunction

    function automatic logic [15:0] mdl_vec();
        return {6'(m_min), 6'(m_sec), m_borrow, (m_state == S_RUN), (m_state == S_EXP), m_pulse};
    endfunction

    task automatic model_reset();
        m_min = 0; m_sec = 0; m_rel_min = 0; m_rel_sec = 0;
        m_state = S_IDLE; m_borrow = 0; m_pulse = 0;
    endtask

    // One clock edge of the timer described in terms of total seconds.
    task automatic model_step(input logic ld, input logic [5:0] lm, input logic [5:0] ls,
                              input logic stt, input logic sp, input logic tk);
        int t;
        m_borrow = 0;
        m_pulse  = 0;
        if (ld) begin
            m_min = (int'(lm) > 59) ? 59 : int'(lm);
            m_sec = (int'(ls) > 59) ? 59 : int'(ls);
            m_rel_min = m_min;
            m_rel_sec = m_sec;
            m_state = S_IDLE;
        end else if (sp) begin
            if (m_state == S_RUN) m_state = S_PAUSE;
        end else if (stt && (m_state == S_IDLE || m_state == S_PAUSE)) begin
            if (m_min * 60 + m_sec != 0) m_state = S_RUN;
        end else if (tk && m_state == S_RUN) begin
            t = m_min * 60 + m_sec;
            if (m_sec == 0) m_borrow = 1;
            t = t - 1;
            m_min = t / 60;
            m_sec = t % 60;
            if (t == 0) begin
                m_pulse = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                if (m_rel_min * 60 + m_rel_sec != 0) begin
                    m_min = m_rel_min;
                    m_sec = m_rel_sec;
                end else begin
                    m_state = S_EXP;
                end
`else
                m_state = S_EXP;
`endif
            end
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge), advance model, return at next falling edge.
    task automatic apply(input logic ld, input logic [5:0] lm, input logic [5:0] ls,
                         input logic stt, input logic sp, input logic tk);
        load = ld; load_min = lm; load_sec = ls; start = stt; stop = sp; tick_1hz = tk;
        @(posedge clk);
        model_step(ld, lm, ls, stt, sp, tk);
        @(negedge clk);
        load = 0; load_min = 0; load_sec = 0; start = 0; stop = 0; tick_1hz = 0;
    endtask

    task automatic test_reset();
        reset_all_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (dut_vec() !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected %h", dut_vec(), 16'h0);
        end
        reset_all_n = 1'b1;
        model_reset();
        apply(0, 0, 0, 0, 0, 0);
        n_tests++;
        if (dut_vec() !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", dut_vec(), 16'h0);
        end
    endtask

    task automatic test_countdown();
        int em[3] = '{1, 1, 0};
        int es[3] = '{1, 0, 59};
        bit eb[3] = '{0, 0, 1};
        apply(1, 6'd1, 6'd2, 0, 0, 0);
        n_tests++;
        if ({min, sec, running} !== {6'd1, 6'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL load_0102: got %0d:%0d run=%b expected 1:2 run=0", min, sec, running);
        end
        apply(0, 0, 0, 1, 0, 0);
        n_tests++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL start_running: got %b expected 1", running);
        end
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 0, 1);
            n_tests++;
            if ({min, sec, borrow_sec} !== {6'(em[i]), 6'(es[i]), eb[i]}) begin
                n_fail++;
                $display("FAIL countdown_tick%0d: got %0d:%0d b=%b expected %0d:%0d b=%b",
                         i, min, sec, borrow_sec, em[i], es[i], eb[i]);
            end
        end
        apply(0, 0, 0, 0, 0, 0);
        n_tests++;
        if (borrow_sec !== 1'b0) begin
            n_fail++;
            $display("FAIL borrow_one_cycle: got %b expected 0", borrow_sec);
        end
    endtask

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    task automatic test_expiry();
        apply(1, 6'd0, 6'd2, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 0);
        apply(0, 0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 0, 1);
        n_tests++;
        if (dut_vec() !== {6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL expiry_edge: got %h expected %h", dut_vec(), {12'd0, 4'b0011});
        end
        apply(0, 0, 0, 0, 0, 0);
        n_tests++;
        if (dut_vec() !== {6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL expiry_pulse_end: got %h expected %h", dut_vec(), {12'd0, 4'b0010});
        end
        apply(0, 0, 0, 1, 0, 1);
        apply(0, 0, 0, 0, 0, 1);
        n_tests++;
        if (dut_vec() !== {6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL expiry_sticky: got %h expected %h", dut_vec(), {12'd0, 4'b0010});
        end
    endtask
`else
    task automatic test_auto_reload();
        apply(1, 6'd0, 6'd2, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 0);
        apply(0, 0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 0, 1);
        n_tests++;
        if (dut_vec() !== {6'd0, 6'd2, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL autoreload_edge: got %h expected %h", dut_vec(), {6'd0, 6'd2, 4'b0101});
        end
        apply(0, 0, 0, 0, 0, 0);
        n_tests++;
        if (dut_vec() !== {6'd0, 6'd2, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL autoreload_pulse_end: got %h expected %h", dut_vec(), {6'd0, 6'd2, 4'b0100});
        end
    endtask
`endif

    task automatic test_saturation();
        apply(1, 6'd63, 6'd63, 0, 0, 0);
        n_tests++;
        if ({min, sec} !== {6'd59, 6'd59}) begin
            n_fail++;
            $display("FAIL saturate: got %0d:%0d expected 59:59", min, sec);
        end
        apply(1, 6'd0, 6'd0, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 0);
        n_tests++;
        if (dut_vec() !== 16'h0) begin
            n_fail++;
            $display("FAIL start_at_zero: got %h expected %h", dut_vec(), 16'h0);
        end
    endtask

    task automatic test_stop_tick();
        apply(1, 6'd0, 6'd10, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 0);
        apply(0, 0, 0, 0, 1, 1);
        n_tests++;
        if ({sec, running} !== {6'd10, 1'b0}) begin
            n_fail++;
            $display("FAIL stop_plus_tick: got sec=%0d run=%b expected sec=10 run=0", sec, running);
        end
        apply(0, 0, 0, 1, 0, 1);
        n_tests++;
        if ({sec, running} !== {6'd10, 1'b1}) begin
            n_fail++;
            $display("FAIL start_plus_tick: got sec=%0d run=%b expected sec=10 run=1", sec, running);
        end
        apply(0, 0, 0, 0, 0, 1);
        n_tests++;
        if ({sec, running} !== {6'd9, 1'b1}) begin
            n_fail++;
            $display("FAIL resume_tick: got sec=%0d run=%b expected sec=9 run=1", sec, running);
        end
    endtask

    task automatic test_async_reset();
        apply(1, 6'd5, 6'd30, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 0);
        n_tests++;
        if ({min, sec, running} !== {6'd5, 6'd30, 1'b1}) begin
            n_fail++;
            $display("FAIL async_setup: got %0d:%0d run=%b expected 5:30 run=1", min, sec, running);
        end
        #2;
        reset_all_n = 1'b0;
        #1;
        n_tests++;
        if (dut_vec() !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset_immediate: got %h expected %h", dut_vec(), 16'h0);
        end
        @(negedge clk);
        #2;
        reset_all_n = 1'b1;
        model_reset();
        @(negedge clk);
        apply(0, 0, 0, 0, 0, 1);
        n_tests++;
        if (dut_vec() !== 16'h0) begin
            n_fail++;
            $display("FAIL async_reset_idle: got %h expected %h", dut_vec(), 16'h0);
        end
    endtask

    task automatic test_random();
        logic       ld, stt, sp, tk;
        logic [5:0] lm, ls;
        for (int i = 0; i < 4000; i++) begin
            ld  = ($urandom_range(0, 99) < 3);
            lm  = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 1));
            ls  = 6'($urandom_range(0, 63));
            stt = ($urandom_range(0, 99) < 10);
            sp  = ($urandom_range(0, 99) < 3);
            tk  = ($urandom_range(0, 99) < 60);
            apply(ld, lm, ls, stt, sp, tk);
            n_tests++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        reset_all_n = 1'b0;
        tick_1hz = 0; load = 0; load_min = 0; load_sec = 0; start = 0; stop = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_countdown();
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        test_expiry();
`else
        test_auto_reload();
`endif
        test_saturation();
        test_stop_tick();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
